parking_exit_fee: RTL and testbench
===================================

// Module: parking_exit_fee
// PURPOSE
// - Exit-gate controller and the read side of the parking entry-time buffer.
// - Accepts an exit request for a car ID, reads that car's stored entry time,
//   computes parked duration (mod-256 clock) and fee, then presents the fee
//   under a valid/ack handshake.
// - On fee acknowledge, emits a one-cycle slot-release pulse to the occupancy logic.
// PARAMETERS
// - RATE       5     fee units per time unit, charged beyond the free period
// - FREE_TIME  2     time units charged at zero fee; duration <= FREE_TIME gives fee 0
// - FEE_W      16    fee output width
// - MAX_FEE    1000  fee saturation ceiling; must be < 2**FEE_W
// PORTS
// - clk            in   1      system clock, rising edge
// - reset          in   1      asynchronous, active-high
// - exit_req       in   1      exit request; qualified by exit_ready
// - exit_id        in   2      car ID being released; valid IDs are 0..2
// - car_present    in   3      occupancy bitmap; bit n set = car n parked
// - current_time   in   8      free-running time base, wraps 255->0
// - exit_ready     out  1      high only in IDLE; request accepted on exit_req & exit_ready
// - buf_read_en    out  1      read strobe to the entry-time buffer
// - buf_car_id     out  2      car ID to the entry-time buffer
// - buf_entry_time in   8      buffer read data; combinational from buf_read_en/buf_car_id
// - fee_valid      out  1      fee, fee_id and duration are valid; held until fee_ack
// - fee            out  FEE_W  computed fee
// - fee_id         out  2      car ID the fee belongs to
// - duration       out  8      parked time units
// - fee_ack        in   1      consumer accepts the fee; ignored unless fee_valid
// - release_valid  out  1      one-cycle pulse: slot release_id is now free
// - release_id     out  2      slot being released
// - exit_err       out  1      one-cycle pulse: request rejected
// BEHAVIOUR
// - Reset: state=IDLE, exit_ready=1; all other outputs 0; internal registers 0.
// - FSM states: IDLE, READ, CALC, DONE, ERR.
// - IDLE
//   - On accept, latch id_r=exit_id and exit_t_r=current_time.
//   - If exit_id==3 or car_present[exit_id]==0, go to ERR; otherwise go to READ.
// - READ (1 cycle)
//   - Drive buf_read_en=1, buf_car_id=id_r.
//   - Register entry_r=buf_entry_time at the closing edge. Go to CALC.
//   - buf_read_en is 0 and buf_car_id holds its last value in all other states.
// - CALC (1 cycle)
//   - dur = (exit_t_r - entry_r) mod 256, 8-bit unsigned wrap.
//   - Entry==exit gives dur 0.
//   - If dur <= FREE_TIME: fee = 0.
//   - Else: fee = (dur - FREE_TIME) * RATE, computed at full width, saturated to MAX_FEE.
//   - Register fee, duration=dur, fee_id=id_r. Go to DONE.
// - DONE
//   - fee_valid=1; fee, duration and fee_id stable while fee_valid is high.
//   - On fee_ack in a cycle with fee_valid=1: next cycle has fee_valid=0,
//     release_valid=1, release_id=id_r, state=IDLE.
//   - release_valid is high for exactly that one cycle.
// - ERR (1 cycle)
//   - exit_err=1; no buffer read, no release. Next state is IDLE.
// - Latency, accept to fee_valid: 3 cycles.
//   - Accept edge -> READ -> CALC -> fee_valid high in the cycle after CALC.
// - exit_req while not exit_ready: ignored, not queued.
// - Requester must hold exit_req until accepted.
// - current_time changes after acceptance have no effect; the exit time is latched.
// - fee_ack asserted early, before fee_valid: ignored.
// - Reset mid-operation (any state): immediate return to IDLE.
//   - fee_valid, release_valid, exit_err and buf_read_en drop asynchronously.
//   - The in-flight request is discarded; no release is issued.
// - One transaction in flight at a time; no pipelining of requests.
// TESTING
// - Defaults, car 1 present, entry 10, exit at time 20 -> buf_read_en 1 for exactly 1 cycle
//   with buf_car_id 1; fee_valid 3 cycles after accept; duration 10, fee 40, fee_id 1.
// - Wrap-around: entry 250, exit at 4 -> duration 10, fee 40.
// - Free period: entry 100, exit 102 -> duration 2, fee 0.
// - Free period: entry 100, exit 103 -> fee 5.
// - Saturation: entry 0, exit 255 -> duration 255, raw 1265 -> fee 1000.
// - Errors: exit_id 3, or exit_id 0 with car_present=3'b110 -> exit_err 1-cycle pulse,
//   buf_read_en never high, no fee_valid, exit_ready back to 1 in the next cycle.
// - Handshake/reset: hold fee_ack low 5 cycles -> fee_valid and outputs stable; then ack
//   -> release_valid 1 cycle with release_id correct. Assert reset in DONE -> all outputs 0,
//   exit_ready 1, no release pulse.

Source files
------------

// File: rtl/parking_exit_fee.sv
// Exit-gate controller for the parking lot.
// Accepts an exit request for a parked car and reads that car's entry time from
// the entry-time buffer. It computes the parked duration on the wrapping 8-bit
// time base and the fee from that duration. The fee is held under a valid/ack
// handshake, and a one-cycle slot-release pulse is sent once the fee is taken.
module parking_exit_fee #(
    parameter int unsigned RATE      = 5,     // fee units per time unit beyond the free period
    parameter int unsigned FREE_TIME = 2,     // durations up to this are free
    parameter int unsigned FEE_W     = 16,    // fee output width
    parameter int unsigned MAX_FEE   = 1000   // saturation ceiling, must fit in FEE_W bits
) (
    input  logic             clk,
    input  logic             reset,
    // exit request side
    input  logic             exit_req,
    input  logic [1:0]       exit_id,
    input  logic [2:0]       car_present,
    input  logic [7:0]       current_time,
    output logic             exit_ready,
    // entry-time buffer read port
    output logic             buf_read_en,
    output logic [1:0]       buf_car_id,
    input  logic [7:0]       buf_entry_time,
    // fee handshake
    output logic             fee_valid,
    output logic [FEE_W-1:0] fee,
    output logic [1:0]       fee_id,
    output logic [7:0]       duration,
    input  logic             fee_ack,
    // occupancy release and error reporting
    output logic             release_valid,
    output logic [1:0]       release_id,
    output logic             exit_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CALC = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    // latched request context
    logic [1:0] id_r;
    logic [7:0] exit_t_r;
    logic [7:0] entry_r;

    // request qualification
    logic       accept;
    logic [3:0] present_ext;
    logic       id_ok;

    // fee datapath
    logic [7:0]       dur;
    logic [31:0]      over_free;
    logic [31:0]      raw_fee;
    logic [FEE_W-1:0] fee_calc;

    // ID 3 has no slot; padding the bitmap with a zero lets it index safely
    // and read back as "not present".
    assign present_ext = {1'b0, car_present};
    assign id_ok       = present_ext[exit_id];
    assign accept      = exit_req && (state_q == IDLE);

    // State register; reset returns to IDLE from any state, dropping the request.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode for the exit transaction.
    always_comb begin
        // NOTE: default first so every path assigns state_d; a missing branch
        // would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (exit_req) begin
                    state_d = id_ok ? READ : ERR;
                end
            end
            READ:    state_d = CALC;
            CALC:    state_d = DONE;
            DONE: begin
                if (fee_ack) begin
                    state_d = IDLE;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status strobes decoded straight from the state; reset clears them asynchronously.
    always_comb begin
        exit_ready  = (state_q == IDLE);
        buf_read_en = (state_q == READ);
        fee_valid   = (state_q == DONE);
        exit_err    = (state_q == ERR);
    end

    // Duration on the wrapping time base and the saturating fee.
    always_comb begin
        dur       = exit_t_r - entry_r;
        over_free = 32'(dur) - 32'(FREE_TIME);
        raw_fee   = over_free * 32'(RATE);
        if (32'(dur) <= 32'(FREE_TIME)) begin
            fee_calc = '0;
        end else if (raw_fee > 32'(MAX_FEE)) begin
            fee_calc = FEE_W'(MAX_FEE);
        end else begin
            fee_calc = raw_fee[FEE_W-1:0];
        end
    end

    // Request context, buffer address, fee results and the release pulse.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every datapath register has a defined reset value because the
        // outputs must read zero straight after reset; there is no storage array here.
        if (reset) begin
            id_r          <= '0;
            exit_t_r      <= '0;
            entry_r       <= '0;
            buf_car_id    <= '0;
            fee           <= '0;
            duration      <= '0;
            fee_id        <= '0;
            release_valid <= 1'b0;
            release_id    <= '0;
        end else begin
            // Exit time is frozen at acceptance so later time-base ticks have no effect.
            if (accept) begin
                id_r     <= exit_id;
                exit_t_r <= current_time;
                // Buffer address only moves for requests that will actually read.
                if (id_ok) begin
                    buf_car_id <= exit_id;
                end
            end

            if (state_q == READ) begin
                entry_r <= buf_entry_time;
            end

            if (state_q == CALC) begin
                fee      <= fee_calc;
                duration <= dur;
                fee_id   <= id_r;
            end

            // Single-cycle pulse on the edge that consumes the fee.
            release_valid <= (state_q == DONE) && fee_ack;
            if ((state_q == DONE) && fee_ack) begin
                release_id <= id_r;
            end
        end
    end

endmodule

// File: tb/tb_parking_exit_fee.sv
// Directed bench for parking_exit_fee with a small entry-time buffer model.
module tb_parking_exit_fee;

    logic        clk;
    logic        reset;
    logic        exit_req;
    logic [1:0]  exit_id;
    logic [2:0]  car_present;
    logic [7:0]  current_time;
    logic        exit_ready;
    logic        buf_read_en;
    logic [1:0]  buf_car_id;
    logic [7:0]  buf_entry_time;
    logic        fee_valid;
    logic [15:0] fee;
    logic [1:0]  fee_id;
    logic [7:0]  duration;
    logic        fee_ack;
    logic        release_valid;
    logic [1:0]  release_id;
    logic        exit_err;

    logic [7:0] entry_mem [4];

    int test_cnt = 0;
    int fail_cnt = 0;

    parking_exit_fee dut (
        .clk            (clk),
        .reset          (reset),
        .exit_req       (exit_req),
        .exit_id        (exit_id),
        .car_present    (car_present),
        .current_time   (current_time),
        .exit_ready     (exit_ready),
        .buf_read_en    (buf_read_en),
        .buf_car_id     (buf_car_id),
        .buf_entry_time (buf_entry_time),
        .fee_valid      (fee_valid),
        .fee            (fee),
        .fee_id         (fee_id),
        .duration       (duration),
        .fee_ack        (fee_ack),
        .release_valid  (release_valid),
        .release_id     (release_id),
        .exit_err       (exit_err)
    );

    // Combinational entry-time buffer.
    assign buf_entry_time = buf_read_en ? entry_mem[buf_car_id] : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a request and follow it to DONE, checking every stage on the way.
    task automatic start_exit(input logic [1:0] id, input logic [7:0] entry,
                              input logic [7:0] exit_t, input int exp_dur, input int exp_fee);
        entry_mem[id] = entry;
        car_present   = 3'b111;
        exit_id       = id;
        current_time  = exit_t;
        exit_req      = 1'b1;
        step();                              // accept edge -> READ
        exit_req      = 1'b0;
        current_time  = exit_t + 8'd50;      // must not affect the latched exit time
        check("read_en_in_read", 32'(buf_read_en), 1);
        check("read_car_id", 32'(buf_car_id), 32'(id));
        check("ready_low_in_read", 32'(exit_ready), 0);
        check("valid_low_in_read", 32'(fee_valid), 0);
        step();                              // CALC
        check("read_en_low_in_calc", 32'(buf_read_en), 0);
        check("valid_low_in_calc", 32'(fee_valid), 0);
        step();                              // DONE, third cycle after accept
        check("fee_valid", 32'(fee_valid), 1);
        check("duration", 32'(duration), 32'(exp_dur));
        check("fee", 32'(fee), 32'(exp_fee));
        check("fee_id", 32'(fee_id), 32'(id));
    endtask

    task automatic ack_exit(input logic [1:0] id);
        fee_ack = 1'b1;
        step();
        fee_ack = 1'b0;
        check("release_pulse", 32'(release_valid), 1);
        check("release_id", 32'(release_id), 32'(id));
        check("valid_drop_after_ack", 32'(fee_valid), 0);
        check("ready_after_ack", 32'(exit_ready), 1);
        step();
        check("release_one_cycle", 32'(release_valid), 0);
    endtask

    task automatic run_err(input logic [1:0] id, input logic [2:0] present);
        car_present  = present;
        exit_id      = id;
        exit_req     = 1'b1;
        step();                              // accept edge -> ERR
        exit_req     = 1'b0;
        check("err_pulse", 32'(exit_err), 1);
        check("err_no_read", 32'(buf_read_en), 0);
        check("err_ready_low", 32'(exit_ready), 0);
        step();
        check("err_one_cycle", 32'(exit_err), 0);
        check("err_ready_back", 32'(exit_ready), 1);
        check("err_no_read_after", 32'(buf_read_en), 0);
        check("err_no_fee", 32'(fee_valid), 0);
        check("err_no_release", 32'(release_valid), 0);
    endtask

    initial begin
        logic [15:0] held_fee;
        reset        = 1'b1;
        exit_req     = 1'b0;
        exit_id      = 2'd0;
        car_present  = 3'b000;
        current_time = 8'd0;
        fee_ack      = 1'b0;
        for (int i = 0; i < 4; i++) entry_mem[i] = 8'd0;

        #12;
        check("rst_ready", 32'(exit_ready), 1);
        check("rst_fee_valid", 32'(fee_valid), 0);
        check("rst_read_en", 32'(buf_read_en), 0);
        check("rst_release", 32'(release_valid), 0);
        check("rst_err", 32'(exit_err), 0);
        check("rst_fee", 32'(fee), 0);
        @(negedge clk);
        reset = 1'b0;

        // Early ack while idle is ignored.
        @(posedge clk); #1;
        fee_ack = 1'b1;
        step();
        fee_ack = 1'b0;
        check("early_ack_no_release", 32'(release_valid), 0);
        check("early_ack_ready", 32'(exit_ready), 1);

        // Basic fee, wrap-around, free period edges, zero duration, saturation.
        start_exit(2'd1, 8'd10,  8'd20,  10,  40);   ack_exit(2'd1);
        start_exit(2'd2, 8'd250, 8'd4,   10,  40);   ack_exit(2'd2);
        start_exit(2'd0, 8'd100, 8'd102, 2,   0);    ack_exit(2'd0);
        start_exit(2'd0, 8'd100, 8'd103, 3,   5);    ack_exit(2'd0);
        start_exit(2'd2, 8'd77,  8'd77,  0,   0);    ack_exit(2'd2);
        start_exit(2'd1, 8'd0,   8'd255, 255, 1000); ack_exit(2'd1);

        // Rejected requests.
        run_err(2'd3, 3'b111);
        run_err(2'd0, 3'b110);

        // Hold ack low for 5 cycles; a second request meanwhile is ignored.
        start_exit(2'd2, 8'd30, 8'd50, 20, 90);
        held_fee = fee;
        for (int i = 0; i < 5; i++) begin
            exit_req = (i < 3);
            exit_id  = 2'd1;
            step();
            check("hold_valid", 32'(fee_valid), 1);
            check("hold_fee", 32'(fee), 32'(held_fee));
            check("hold_dur", 32'(duration), 20);
            check("hold_id", 32'(fee_id), 2);
            check("hold_no_release", 32'(release_valid), 0);
        end
        exit_req = 1'b0;
        ack_exit(2'd2);
        check("busy_req_not_queued", 32'(buf_read_en), 0);

        // Reset while DONE: outputs drop immediately, no release afterwards.
        start_exit(2'd1, 8'd5, 8'd15, 10, 40);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(fee_valid), 0);
        check("mid_rst_ready", 32'(exit_ready), 1);
        check("mid_rst_fee", 32'(fee), 0);
        check("mid_rst_release", 32'(release_valid), 0);
        @(negedge clk);
        reset   = 1'b0;
        fee_ack = 1'b1;
        step();
        fee_ack = 1'b0;
        check("post_rst_no_release", 32'(release_valid), 0);
        check("post_rst_ready", 32'(exit_ready), 1);
        check("post_rst_no_valid", 32'(fee_valid), 0);

        // Normal operation resumes after reset.
        start_exit(2'd0, 8'd200, 8'd210, 10, 40);
        ack_exit(2'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
